// File: rtl/mure_pkg.sv
// Shared types for the multiple-retirement tracer: the per-lane uop entry
// and the instruction-type codes that collapse a row to a single uop.
package mure_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned ITYPE_W = 3;

  localparam logic [ITYPE_W-1:0] ITYPE_EXC = 3'd1;
  localparam logic [ITYPE_W-1:0] ITYPE_INT = 3'd2;

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [ITYPE_W-1:0] itype;
    logic              compressed;
    logic [1:0]        priv;
  } uop_entry_s;

  function automatic logic is_exc_int(input logic [ITYPE_W-1:0] itype);
    return (itype == ITYPE_EXC) || (itype == ITYPE_INT);
  endfunction

endpackage

// File: rtl/mure_lane_finder.sv
// Single-cycle priority search for the first eligible lane at or above ptr.
// Only built when MURE_SCHED_SKIP_EN is defined; the default build has no finder.
`ifdef MURE_SCHED_SKIP_EN
module mure_lane_finder #(
  parameter  int unsigned NRET   = 2,
  localparam int unsigned LANE_W = $clog2(NRET)
) (
  input  logic [NRET-1:0]   elig,
  input  logic [LANE_W-1:0] ptr,
  output logic              found,
  output logic [LANE_W-1:0] lane,
  output logic              more_after
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    found      = 1'b0;
    lane       = '0;
    more_after = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      if (elig[i] && (i >= int'(ptr))) begin
        if (!found) begin
          found = 1'b1;
          lane  = LANE_W'(i);
        end else begin
          more_after = 1'b1;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/mure_uop_scheduler.sv
// Walks the head row of the per-commit-port FIFO bank, emitting one uop per cycle.
// Optional build macro MURE_SCHED_SKIP_EN: skip ineligible lanes in a single cycle.
module mure_uop_scheduler
  import mure_pkg::*;
#(
  parameter  int unsigned NRET   = 2,
  localparam int unsigned LANE_W = $clog2(NRET)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   row_empty_i,
  input  uop_entry_s [NRET-1:0]  row_i,
  output logic                   pop_o,
  output logic                   uop_valid_o,
  output uop_entry_s             uop_o,
  output logic [LANE_W-1:0]      lane_idx_o,
  output logic                   last_o,
  input  logic                   uop_ready_i,
  output logic                   busy_o
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NRET - 1);

  logic [LANE_W-1:0] ptr_q, ptr_d;
  logic [NRET-1:0]   elig;
  logic              found;
  logic [LANE_W-1:0] cand;
  logic              cand_exc;
  logic              row_done;
  logic              adv;

  // Exception/interrupt lanes carry trace information even without a retired instruction.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NRET; i++) begin
      elig[i] = row_i[i].valid || is_exc_int(row_i[i].itype);
    end
  end

  assign cand_exc = is_exc_int(row_i[cand].itype);

`ifdef MURE_SCHED_SKIP_EN
  logic more_after;

  mure_lane_finder #(.NRET(NRET)) u_lane_finder (
    .elig       (elig),
    .ptr        (ptr_q),
    .found      (found),
    .lane       (cand),
    .more_after (more_after)
  );

  // With no eligible lane left the whole row is dropped at once.
  assign row_done = found ? (cand_exc || (cand == LAST_LANE) || !more_after) : 1'b1;
`else
  assign cand     = ptr_q;
  assign found    = elig[ptr_q];
  assign row_done = (found && cand_exc) || (ptr_q == LAST_LANE);
`endif

  assign adv = !flush_i && !row_empty_i && (!uop_valid_o || uop_ready_i);

  // The bank must not lose a row while the scheduler is held in reset.
  assign pop_o  = rst_ni && adv && row_done;
  assign busy_o = uop_valid_o || (ptr_q != '0);

  always_comb begin
    ptr_d = ptr_q;
    if (flush_i) begin
      ptr_d = '0;
    end else if (adv) begin
      ptr_d = row_done ? '0 : cand + LANE_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      uop_valid_o <= 1'b0;
      uop_o       <= '0;
      lane_idx_o  <= '0;
      last_o      <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (flush_i) begin
        uop_valid_o <= 1'b0;
      end else if (adv && found) begin
        uop_valid_o <= 1'b1;
        uop_o       <= row_i[cand];
        lane_idx_o  <= cand;
        last_o      <= row_done;
      end else if (uop_valid_o && uop_ready_i) begin
        uop_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mure_uop_scheduler.sv
// Self-checking bench for mure_uop_scheduler: directed scenarios plus a
// randomized run scored against a row-level model of the emitted uop stream.
module tb_mure_uop_scheduler;
  import mure_pkg::*;

  localparam int NRET = 2;
  localparam int LANE_W = $clog2(NRET);

  typedef uop_entry_s [NRET-1:0] row_t;
  typedef struct {
    uop_entry_s u;
    int         lane;
    bit         last;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic              row_empty_i = 1'b1;
  row_t              row_i = '0;
  logic              pop_o;
  logic              uop_valid_o;
  uop_entry_s        uop_o;
  logic [LANE_W-1:0] lane_idx_o;
  logic              last_o;
  logic              uop_ready_i = 1'b1;
  logic              busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  row_t bank[$];
  exp_t exp_q[$];

  mure_uop_scheduler #(.NRET(NRET)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .row_empty_i (row_empty_i),
    .row_i       (row_i),
    .pop_o       (pop_o),
    .uop_valid_o (uop_valid_o),
    .uop_o       (uop_o),
    .lane_idx_o  (lane_idx_o),
    .last_o      (last_o),
    .uop_ready_i (uop_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic uop_entry_s mk(input bit v, input logic [31:0] pc, input logic [2:0] it);
    uop_entry_s u;
    u = '0;
    u.valid = v;
    u.pc    = pc;
    u.itype = it;
    return u;
  endfunction

  // Row-level model: which lanes come out, in order, and which one is flagged last.
  task automatic enqueue_row(input row_t r);
    int lanes[$];
    bit stop_exc;
    exp_t e;
    stop_exc = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      bit trap;
      trap = (r[i].itype == 3'd1) || (r[i].itype == 3'd2);
      if (r[i].valid || trap) begin
        lanes.push_back(i);
        if (trap) break;
      end
    end
    for (int k = 0; k < lanes.size(); k++) begin
      int l;
      bit trap;
      l = lanes[k];
      trap = (r[l].itype == 3'd1) || (r[l].itype == 3'd2);
      e.u    = r[l];
      e.lane = l;
`ifdef MURE_SCHED_SKIP_EN
      e.last = (k == lanes.size() - 1);
`else
      e.last = trap || (l == NRET - 1);
`endif
      exp_q.push_back(e);
    end
  endtask

  function automatic row_t rand_row();
    row_t r;
    for (int i = 0; i < NRET; i++) begin
      int x;
      r[i].valid      = ($urandom_range(0, 9) < 7);
      r[i].pc         = $urandom;
      r[i].compressed = 1'($urandom_range(0, 1));
      r[i].priv       = 2'($urandom_range(0, 3));
      x = $urandom_range(0, 19);
      if (x == 0)      r[i].itype = 3'd1;
      else if (x == 1) r[i].itype = 3'd2;
      else if (x < 5)  r[i].itype = 3'($urandom_range(3, 7));
      else             r[i].itype = 3'd0;
    end
    return r;
  endfunction

  task automatic pair_row();
    row_i[0] = mk(1'b1, 32'h100, 3'd0);
    row_i[1] = mk(1'b1, 32'h104, 3'd0);
    row_empty_i = 1'b0;
  endtask

  initial begin
    bit         pop_seen, hold_seen;
    uop_entry_s held_u;
    logic [LANE_W-1:0] held_lane;
    logic       held_last;
    int         ncyc;

    // Reset state
    #12;
    check("rst_valid", uop_valid_o, 0);
    check("rst_uop", uop_o, 0);
    check("rst_lane", lane_idx_o, 0);
    check("rst_last", last_o, 0);
    check("rst_busy", busy_o, 0);
    row_empty_i = 1'b0;
    #1;
    check("rst_pop", pop_o, 0);
    row_empty_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Two valid lanes, back to back
    pair_row();
    #1;
    check("t1_pop0", pop_o, 0);
    tick();
    check("t1_v0", uop_valid_o, 1);
    check("t1_pc0", uop_o.pc, 32'h100);
    check("t1_lane0", lane_idx_o, 0);
    check("t1_last0", last_o, 0);
    check("t1_pop1", pop_o, 1);
    tick();
    row_empty_i = 1'b1;
    check("t1_pc1", uop_o.pc, 32'h104);
    check("t1_lane1", lane_idx_o, 1);
    check("t1_last1", last_o, 1);
    tick();
    check("t1_drain", uop_valid_o, 0);
    check("t1_idle", busy_o, 0);

    // All-invalid row
    row_i[0] = mk(1'b0, 32'h300, 3'd0);
    row_i[1] = mk(1'b0, 32'h304, 3'd0);
    row_empty_i = 1'b0;
    #1;
`ifdef MURE_SCHED_SKIP_EN
    check("t2_pop_c1", pop_o, 1);
    tick();
    row_empty_i = 1'b1;
    check("t2_novalid", uop_valid_o, 0);
    check("t2_busy", busy_o, 0);
`else
    check("t2_pop_c1", pop_o, 0);
    tick();
    check("t2_novalid", uop_valid_o, 0);
    check("t2_busy_mid", busy_o, 1);
    check("t2_pop_c2", pop_o, 1);
    tick();
    row_empty_i = 1'b1;
    check("t2_novalid2", uop_valid_o, 0);
    check("t2_busy", busy_o, 0);
`endif

    // Exception row collapses to one uop
    row_i[0] = mk(1'b1, 32'h200, 3'd1);
    row_i[1] = mk(1'b1, 32'h204, 3'd1);
    row_empty_i = 1'b0;
    #1;
    check("t3_pop", pop_o, 1);
    tick();
    row_empty_i = 1'b1;
    check("t3_valid", uop_valid_o, 1);
    check("t3_pc", uop_o.pc, 32'h200);
    check("t3_lane", lane_idx_o, 0);
    check("t3_last", last_o, 1);
    tick();
    check("t3_drain", uop_valid_o, 0);

    // Back-pressure holds the output register
    pair_row();
    uop_ready_i = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t4_hold_pc", uop_o.pc, 32'h100);
      check("t4_hold_valid", uop_valid_o, 1);
      check("t4_hold_pop", pop_o, 0);
      check("t4_hold_busy", busy_o, 1);
      tick();
    end
    check("t4_still", uop_o.pc, 32'h100);
    uop_ready_i = 1'b1;
    #1;
    check("t4_pop", pop_o, 1);
    tick();
    row_empty_i = 1'b1;
    check("t4_next_pc", uop_o.pc, 32'h104);
    check("t4_next_lane", lane_idx_o, 1);
    tick();
    check("t4_drain", uop_valid_o, 0);

    // Flush mid-row
    pair_row();
    tick();
    check("t5_pre", uop_valid_o, 1);
    flush_i = 1'b1;
    #1;
    check("t5_pop", pop_o, 0);
    tick();
    flush_i = 1'b0;
    row_empty_i = 1'b1;
    check("t5_valid", uop_valid_o, 0);
    check("t5_busy", busy_o, 0);

    // Asynchronous reset mid-row restarts at lane 0
    pair_row();
    tick();
    check("t6_pre_pc", uop_o.pc, 32'h100);
    rst_ni = 1'b0;
    #1;
    check("t6_valid", uop_valid_o, 0);
    check("t6_uop", uop_o, 0);
    check("t6_lane", lane_idx_o, 0);
    check("t6_last", last_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_pop", pop_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    check("t6_re_pc", uop_o.pc, 32'h100);
    check("t6_re_lane", lane_idx_o, 0);
    tick();
    row_empty_i = 1'b1;
    check("t6_re_pc1", uop_o.pc, 32'h104);
    tick();
    check("t6_drain", uop_valid_o, 0);

    // Randomized traffic against the row-level model
    pop_seen  = 1'b0;
    hold_seen = 1'b0;
    held_u    = '0;
    held_lane = '0;
    held_last = 1'b0;
    ncyc = 3000;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      tick();
      if (pop_seen) begin
        check("pop_nonempty", bank.size() != 0, 1);
        if (bank.size() != 0) void'(bank.pop_front());
      end
      if (hold_seen) begin
        check("hold_valid", uop_valid_o, 1);
        check("hold_uop", uop_o, held_u);
        check("hold_lane", lane_idx_o, held_lane);
        check("hold_last", last_o, held_last);
      end
      if (cyc < ncyc - 200 && bank.size() < 4 && $urandom_range(0, 2) == 0) begin
        row_t r;
        r = rand_row();
        bank.push_back(r);
        enqueue_row(r);
      end
      row_empty_i = (bank.size() == 0);
      row_i       = (bank.size() != 0) ? bank[0] : '0;
      uop_ready_i = ($urandom_range(0, 9) < 7);
      #1;
      pop_seen  = pop_o;
      hold_seen = uop_valid_o && !uop_ready_i;
      held_u    = uop_o;
      held_lane = lane_idx_o;
      held_last = last_o;
      if (uop_valid_o) check("busy_when_valid", busy_o, 1);
      if (uop_valid_o && uop_ready_i) begin
        check("uop_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("rnd_uop", uop_o, e.u);
          check("rnd_lane", lane_idx_o, e.lane);
          check("rnd_last", last_o, e.last);
        end
      end
    end
    tick();
    check("end_exp_left", exp_q.size(), 0);
    check("end_bank_left", bank.size(), 0);
    check("end_busy", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
